system_dispatch_unit: RTL and testbench
=======================================

SYSTEM_DISPATCH_UNIT -- requirements
Module: system_dispatch_unit

Interface
REQ-001 SHALL have parameter ID_W, default 32: width of the system id field presented to the pipeline.
REQ-002 SHALL have parameter ADDR_W, default 32: width of the system data_address field.
REQ-003 SHALL have parameter CNT_W, default 16: width of the dispatch count.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: begin a dispatch batch; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1: terminate the current batch.
REQ-008 SHALL have port base_address  input  ADDR_W: data_address of the first slot.
REQ-009 SHALL have port stride  input  ADDR_W: address increment between consecutive ids.
REQ-010 SHALL have port count  input  CNT_W: number of slots in the batch.
REQ-011 SHALL have port out_valid  output  1: out_id and out_data_address hold a slot offer.
REQ-012 SHALL have port out_ready  input  1: downstream pipeline stage accepts the slot.
REQ-013 SHALL have port out_id  output  ID_W: system.id for the pipeline pass.
REQ-014 SHALL have port out_data_address  output  ADDR_W: system.data_address for the pipeline pass.
REQ-015 SHALL have port busy  output  1: high in ISSUE and DONE.
REQ-016 SHALL have port done  output  1: single-cycle pulse marking batch completion.

Function
REQ-017 SHALL implement three states: IDLE, ISSUE, DONE; all outputs driven from registers.
REQ-018 In IDLE with start=1 and count!=0, SHALL latch base_address, stride and count, load out_id=0 and out_data_address=base_address, and enter ISSUE on the next edge.
REQ-019 In IDLE with start=1 and count=0, SHALL enter DONE without ever asserting out_valid.
REQ-020 out_valid SHALL be 1 exactly while in ISSUE; the first offer appears in the cycle after start is sampled (latency 1).
REQ-021 A transfer SHALL occur on any edge where out_valid=1 and out_ready=1; throughput one slot per cycle with out_ready held high.
REQ-022 While out_valid=1 and out_ready=0, out_id and out_data_address SHALL hold stable.
REQ-023 On each transfer except the last, out_id SHALL increment by 1 and out_data_address SHALL add the latched stride, modulo 2^ADDR_W (wraps silently).
REQ-024 out_id SHALL be the zero-extended slot index; index width is CNT_W and ID_W >= CNT_W.
REQ-025 On the transfer of slot count-1, SHALL leave ISSUE for DONE; out_valid is 0 on the following cycle.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 start while busy=1 SHALL be ignored; changes to base_address, stride and count after latching SHALL not affect the batch.
REQ-028 abort=1 in ISSUE or DONE SHALL force IDLE on the next edge, with no done pulse; a transfer handshaking on that same edge counts as delivered, but no further slot is offered.
REQ-029 abort has priority over the last-transfer transition; abort and start in IDLE together SHALL leave the block in IDLE.

Reset
REQ-030 reset=1 SHALL force state IDLE, out_valid=0, done=0, busy=0, out_id=0 and out_data_address=0 on the next edge, overriding start and abort.
REQ-031 reset mid-batch SHALL discard the batch with no done pulse; the first start after reset is sampled normally.

Verification
REQ-032 base=0x1000, stride=0x40, count=4, out_ready=1: ids 0..3 at 0x1000, 0x1040, 0x1080, 0x10C0 on four consecutive cycles, then done pulse for one cycle.
REQ-033 Same batch with out_ready toggled pseudo-randomly: every offer held stable until it is accepted, no slot dropped or duplicated, exactly one done.
REQ-034 count=0 start: out_valid never asserted, done pulses on the cycle after start, busy high for that one cycle.
REQ-035 base=0xFFFFFFF0, stride=0x10, count=3: addresses 0xFFFFFFF0, 0x00000000, 0x00000010 (wrap).
REQ-036 abort asserted after the second transfer of a count=8 batch: out_valid low on the next cycle, no done pulse, busy=0, and a following start runs a clean batch from id 0.
REQ-037 reset asserted during ISSUE with out_ready=0: all outputs at reset values on the next cycle, and start during reset is ignored.

Source files
------------

// File: rtl/system_dispatch_unit.sv
// Dispatch unit: expands {base_address, stride, count} into a stream of (id, data_address) slot offers.
// Latency: first offer appears the cycle after start is sampled; one slot per cycle when out_ready stays high.
// Backpressure: the current offer holds stable while out_ready is low; abort drops the remaining slots.
module system_dispatch_unit #(
    parameter int ID_W   = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic [ADDR_W-1:0] out_data_address,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    idx, idx_nxt;
    logic [CNT_W-1:0]    count_q, count_nxt;
    logic [ADDR_W-1:0]   stride_q, stride_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                valid_q, busy_q, done_q;
    logic                last_slot;

    assign last_slot = (idx == (count_q - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            count_q  <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            count_q  <= count_nxt;
            stride_q <= stride_nxt;
            addr_q   <= addr_nxt;
            // Status outputs are registered copies of the next state.
            valid_q  <= (state_nxt == ISSUE);
            busy_q   <= (state_nxt != IDLE);
            done_q   <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        count_nxt  = count_q;
        stride_nxt = stride_q;
        addr_nxt   = addr_q;
        case (state)
            IDLE: begin
                // abort together with start wins and keeps the block idle.
                if (start && !abort) begin
                    count_nxt  = count;
                    stride_nxt = stride;
                    idx_nxt    = '0;
                    addr_nxt   = base_address;
                    state_nxt  = (count != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    if (last_slot) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt  = idx + CNT_W'(1);
                        addr_nxt = addr_q + stride_q;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign out_valid        = valid_q;
    assign out_id           = ID_W'(idx);
    assign out_data_address = addr_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_system_dispatch_unit.sv
// Directed bench for system_dispatch_unit: linear steps with hand-computed expectations.
module tb_system_dispatch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] base_address;
    logic [31:0] stride;
    logic [15:0] count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_id;
    logic [31:0] out_data_address;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    system_dispatch_unit #(.ID_W(32), .ADDR_W(32), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .base_address     (base_address),
        .stride           (stride),
        .count            (count),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_id           (out_id),
        .out_data_address (out_data_address),
        .busy             (busy),
        .done             (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_offer(input string tag, input logic [31:0] id, input logic [31:0] addr);
        chk1({tag, "_valid"}, out_valid, 1'b1);
        chk32({tag, "_id"}, out_id, id);
        chk32({tag, "_addr"}, out_data_address, addr);
        chk1({tag, "_busy"}, busy, 1'b1);
        chk1({tag, "_done"}, done, 1'b0);
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
    endtask

    task automatic chk_done(input string tag);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b1);
        chk1({tag, "_done"}, done, 1'b1);
    endtask

    initial begin
        logic [11:0] pat;
        logic        rdy;
        logic        in_issue;
        logic        exp_done;
        int          exp_idx;
        int          done_cnt;

        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_address = '0; stride = '0; count = '0;
        step(); step();
        chk_idle("rst");
        chk32("rst_id", out_id, 32'h0);
        chk32("rst_addr", out_data_address, 32'h0);
        reset = 1'b0;
        step();
        chk_idle("rst_rel");

        // Basic batch, full throughput; input changes after latching must not matter.
        base_address = 32'h1000; stride = 32'h40; count = 16'd4; out_ready = 1'b1; start = 1'b1;
        step();
        chk_offer("b0", 32'd0, 32'h1000);
        base_address = 32'hDEAD0000; stride = 32'h3; count = 16'd9;
        step();
        chk_offer("b1", 32'd1, 32'h1040);
        step();
        chk_offer("b2", 32'd2, 32'h1080);
        start = 1'b0;
        step();
        chk_offer("b3", 32'd3, 32'h10C0);
        step();
        chk_done("b_done");
        step();
        chk_idle("b_idle");

        // Backpressure with a fixed ready pattern, tracked by a small model.
        base_address = 32'h1000; stride = 32'h40; count = 16'd3; out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk_offer("bp_first", 32'd0, 32'h1000);
        pat = 12'b0110_1001_0100;
        in_issue = 1'b1; exp_idx = 0; done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            rdy = pat[c];
            out_ready = rdy;
            exp_done = 1'b0;
            step();
            if (in_issue && rdy) begin
                if (exp_idx == 2) begin
                    in_issue = 1'b0;
                    exp_done = 1'b1;
                end else begin
                    exp_idx++;
                end
            end
            if (done) done_cnt++;
            chk1("bp_valid", out_valid, in_issue);
            chk1("bp_done", done, exp_done);
            if (in_issue) begin
                chk32("bp_id", out_id, 32'(exp_idx));
                chk32("bp_addr", out_data_address, 32'h1000 + 32'(exp_idx) * 32'h40);
            end
        end
        chk32("bp_done_count", 32'(done_cnt), 32'd1);
        chk_idle("bp_idle");

        // Zero-count batch goes straight to DONE.
        out_ready = 1'b1; count = 16'd0; base_address = 32'h2000; start = 1'b1;
        step();
        start = 1'b0;
        chk_done("z_done");
        step();
        chk_idle("z_idle");

        // Address wrap.
        base_address = 32'hFFFFFFF0; stride = 32'h10; count = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk_offer("w0", 32'd0, 32'hFFFFFFF0);
        step();
        chk_offer("w1", 32'd1, 32'h00000000);
        step();
        chk_offer("w2", 32'd2, 32'h00000010);
        step();
        chk_done("w_done");
        step();
        chk_idle("w_idle");

        // Abort after the second transfer of an 8-slot batch.
        base_address = 32'h0; stride = 32'h4; count = 16'd8; start = 1'b1;
        step();
        start = 1'b0;
        chk_offer("a0", 32'd0, 32'h0);
        step();
        chk_offer("a1", 32'd1, 32'h4);
        step();
        chk_offer("a2", 32'd2, 32'h8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("a_abort");
        step();
        chk_idle("a_after");
        base_address = 32'h500; stride = 32'h1; count = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk_offer("a_re0", 32'd0, 32'h500);
        step();
        chk_offer("a_re1", 32'd1, 32'h501);
        step();
        chk_done("a_re_done");
        step();
        chk_idle("a_re_idle");

        // Abort and start together in IDLE stay idle.
        start = 1'b1; abort = 1'b1; count = 16'd4;
        step();
        start = 1'b0; abort = 1'b0;
        chk_idle("as_idle");
        step();
        chk_idle("as_idle2");

        // Last transfer and abort on the same edge: abort wins, no done.
        base_address = 32'h40; stride = 32'h4; count = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk_offer("la0", 32'd0, 32'h40);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("la_abort");

        // Reset mid-batch under backpressure; start during reset ignored.
        base_address = 32'h3000; stride = 32'h8; count = 16'd5; out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk_offer("r0", 32'd0, 32'h3000);
        step();
        chk_offer("r0_hold", 32'd0, 32'h3000);
        reset = 1'b1; start = 1'b1;
        step();
        chk_idle("r_rst");
        chk32("r_rst_id", out_id, 32'h0);
        chk32("r_rst_addr", out_data_address, 32'h0);
        step();
        chk_idle("r_rst2");
        reset = 1'b0; start = 1'b0;
        step();
        chk_idle("r_rel");
        base_address = 32'h77; count = 16'd1; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk_offer("r_new", 32'd0, 32'h77);
        step();
        chk_done("r_new_done");
        step();
        chk_idle("r_new_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
